// File: rtl/store_align_buffer.sv
// Store alignment buffer: lane-aligns execute-stage stores, builds byte enables, and queues them for the dcache.
// Optional store-to-load forwarding lookup is built only when STORE_FWD_EN is defined.
module store_align_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  funct3,
  output logic        st_misaligned,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_din,
  output logic [3:0]  dc_we,
  output logic        buf_empty,
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_mask
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    we_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misaligned_q, misaligned_d;

  logic          legal, accept, enq, deq;
  logic [1:0]    offs;
  logic [3:0]    al_we;
  logic [31:0]   al_data;

  assign offs = st_addr[1:0];

  always_comb begin
    legal   = 1'b0;
    al_we   = 4'b0000;
    al_data = st_data;
    case (funct3)
      3'd0: begin
        legal   = 1'b1;
        al_we   = 4'b0001 << offs;
        al_data = {4{st_data[7:0]}};
      end
      3'd1: begin
        legal   = ~offs[0];
        al_we   = 4'b0011 << offs;
        al_data = {2{st_data[15:0]}};
      end
      3'd2: begin
        legal   = (offs == 2'b00);
        al_we   = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  // Status outputs come only from registered count, so st_ready never sees dc_ready.
  assign st_ready  = (count_q != FULL_CNT);
  assign dc_valid  = (count_q != '0);
  assign buf_empty = (count_q == '0);
  assign accept    = st_valid & st_ready;
  assign enq       = accept & legal;
  assign deq       = dc_valid & dc_ready;

  always_comb begin
    wr_ptr_d     = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    misaligned_d = accept & ~legal;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // NOTE: storage is not reset; entries are only observed while count marks them valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= st_addr[31:2];
      data_mem[wr_ptr_q] <= al_data;
      we_mem[wr_ptr_q]   <= al_we;
    end
  end

  assign st_misaligned = misaligned_q;

  // Head fields are gated so an empty buffer presents all-zero address, data and enables.
  assign dc_addr = dc_valid ? {addr_mem[rd_ptr_q], 2'b00} : 32'h0;
  assign dc_din  = dc_valid ? data_mem[rd_ptr_q] : 32'h0;
  assign dc_we   = dc_valid ? we_mem[rd_ptr_q] : 4'h0;

`ifdef STORE_FWD_EN
  logic [AW-1:0] fwd_idx;
  logic [1:0]    unused_ld_offs;

  assign unused_ld_offs = ld_addr[1:0];

  // Walk oldest to youngest so younger matches overwrite older bytes.
  always_comb begin
    fwd_mask = 4'h0;
    fwd_data = 32'h0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_mem[fwd_idx] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (we_mem[fwd_idx][b]) begin
            fwd_mask[b]       = 1'b1;
            fwd_data[8*b +: 8] = data_mem[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign fwd_hit = |fwd_mask;
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = 32'h0;
  assign fwd_mask       = 4'h0;
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer (DEPTH=2): alignment, misalignment drop, full/stall, reset, forwarding.
module tb_store_align_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  funct3;
  logic        st_misaligned;
  logic        dc_valid;
  logic        dc_ready;
  logic [31:0] dc_addr;
  logic [31:0] dc_din;
  logic [3:0]  dc_we;
  logic        buf_empty;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  int checks   = 0;
  int failures = 0;

  store_align_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .funct3(funct3), .st_misaligned(st_misaligned),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr), .dc_din(dc_din), .dc_we(dc_we),
    .buf_empty(buf_empty), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_mask(fwd_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    funct3   = f;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    dc_ready = 1'b0;
    ld_addr = 32'h0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    check("rst_st_ready",   32'(st_ready),      32'h1);
    check("rst_dc_valid",   32'(dc_valid),      32'h0);
    check("rst_dc_addr",    dc_addr,            32'h0);
    check("rst_dc_din",     dc_din,             32'h0);
    check("rst_dc_we",      32'(dc_we),         32'h0);
    check("rst_misaligned", 32'(st_misaligned), 32'h0);
    check("rst_buf_empty",  32'(buf_empty),     32'h1);
    check("rst_fwd_hit",    32'(fwd_hit),       32'h0);
    check("rst_fwd_data",   fwd_data,           32'h0);
    check("rst_fwd_mask",   32'(fwd_mask),      32'h0);
    step();
    rst = 1'b0;
    step();

    // sb to byte 3, dcache ready: visible one cycle later, drained the next
    dc_ready = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("sb_dc_valid",  32'(dc_valid),  32'h1);
    check("sb_dc_addr",   dc_addr,        32'h0000_1000);
    check("sb_dc_we",     32'(dc_we),     32'h8);
    check("sb_dc_din",    dc_din,         32'hABAB_ABAB);
    check("sb_not_empty", 32'(buf_empty), 32'h0);
    step();
    check("sb_drained",   32'(buf_empty), 32'h1);
    check("sb_we_empty",  32'(dc_we),     32'h0);

    // sh aligned, then sh misaligned, then illegal funct3, with dcache stalled
    dc_ready = 1'b0;
    drive(1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234);
    step();
    check("sh_dc_we",   32'(dc_we), 32'hC);
    check("sh_dc_din",  dc_din,     32'h1234_1234);
    check("sh_dc_addr", dc_addr,    32'h0000_2000);
    check("sh_no_mis",  32'(st_misaligned), 32'h0);
    drive(1'b1, 3'd1, 32'h0000_2001, 32'h0000_5678);
    step();
    check("shmis_pulse",    32'(st_misaligned), 32'h1);
    check("shmis_st_ready", 32'(st_ready),      32'h1);
    check("shmis_head_we",  32'(dc_we),         32'hC);
    drive(1'b1, 3'd3, 32'h0000_5000, 32'h0000_0099);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("illegal_pulse",    32'(st_misaligned), 32'h1);
    check("illegal_st_ready", 32'(st_ready),      32'h1);
    step();
    check("pulse_cleared", 32'(st_misaligned), 32'h0);
    dc_ready = 1'b1;
    step();
    check("sh_drain_empty", 32'(buf_empty), 32'h1);

    // Three back-to-back sw with dcache stalled; third waits for space
    dc_ready = 1'b0;
    drive(1'b1, 3'd2, 32'h0000_4000, 32'hAAAA_0001);
    step();
    check("sw1_st_ready", 32'(st_ready), 32'h1);
    drive(1'b1, 3'd2, 32'h0000_4004, 32'hAAAA_0002);
    step();
    check("full_st_ready", 32'(st_ready), 32'h0);
    check("full_head",     dc_addr,       32'h0000_4000);
    drive(1'b1, 3'd2, 32'h0000_4008, 32'hAAAA_0003);
    step();
    check("stall_st_ready",  32'(st_ready), 32'h0);
    check("stall_head_addr", dc_addr,       32'h0000_4000);
    check("stall_head_din",  dc_din,        32'hAAAA_0001);
    check("stall_head_we",   32'(dc_we),    32'hF);
    dc_ready = 1'b1;
    step();
    check("deq1_head_addr", dc_addr,       32'h0000_4004);
    check("deq1_head_din",  dc_din,        32'hAAAA_0002);
    check("deq1_st_ready",  32'(st_ready), 32'h1);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("simul_head_addr", dc_addr,       32'h0000_4008);
    check("simul_head_din",  dc_din,        32'hAAAA_0003);
    check("simul_dc_valid",  32'(dc_valid), 32'h1);
    check("simul_st_ready",  32'(st_ready), 32'h1);
    step();
    check("sw_drain_empty", 32'(buf_empty), 32'h1);

    // Reset asserted with two entries queued clears immediately
    dc_ready = 1'b0;
    drive(1'b1, 3'd2, 32'h0000_6000, 32'h0000_0006);
    step();
    drive(1'b1, 3'd2, 32'h0000_6004, 32'h0000_0007);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("pre_rst_full", 32'(st_ready), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dc_valid",  32'(dc_valid),  32'h0);
    check("async_rst_buf_empty", 32'(buf_empty), 32'h1);
    check("async_rst_st_ready",  32'(st_ready),  32'h1);
    step();
    rst = 1'b0;
    step();

    // Forwarding: sw then overlapping sb to the same word
    drive(1'b1, 3'd2, 32'h0000_3000, 32'h1122_3344);
    step();
    drive(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00EE);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    ld_addr = 32'h0000_3000;
    #1;
`ifdef STORE_FWD_EN
    check("fwd_hit",  32'(fwd_hit),  32'h1);
    check("fwd_mask", 32'(fwd_mask), 32'hF);
    check("fwd_data", fwd_data,      32'h1122_EE44);
`else
    check("fwd_hit_off",  32'(fwd_hit),  32'h0);
    check("fwd_mask_off", 32'(fwd_mask), 32'h0);
    check("fwd_data_off", fwd_data,      32'h0);
`endif
    ld_addr = 32'h0000_3004;
    #1;
    check("fwd_miss_hit", 32'(fwd_hit), 32'h0);
    check("fwd_order_head", dc_addr, 32'h0000_3000);
    dc_ready = 1'b1;
    step();
    check("fwd_second_we", 32'(dc_we), 32'h2);
    step();
    check("final_empty", 32'(buf_empty), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
